// File: rtl/memory_arbiter.sv
// Purpose : share one memory port between the core and the Interpreter (ctrl), one transaction at a time.
// Latency : request seen in cycle t -> mem strobe in t+1; mem_response in t+1+k -> response pulse in t+2+k.
// Backpr. : level requests wait in IDLE until granted; a locked-out core pends with no response.
//
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   core_* / ctrl_*       - requester ports: read/write level requests, address, write data,
//                           registered read data and a one-cycle response pulse
//   ctrl_lock             - while high only ctrl may be granted
//   mem_*                 - single memory port: strobes, address, write data, read data, response
//   grant_core/grant_ctrl - ownership flags, high in BUSY and RESP
//   timeout_error         - sticky watchdog flag, cleared by clear_error (a new timeout wins)
module memory_arbiter #(
    parameter int BUS_WIDTH      = 32,
    parameter bit ROUND_ROBIN    = 1'b1,
    parameter int TIMEOUT_BITS   = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 core_read,
    input  logic                 core_write,
    input  logic [BUS_WIDTH-1:0] core_address,
    input  logic [BUS_WIDTH-1:0] core_write_data,
    output logic [BUS_WIDTH-1:0] core_read_data,
    output logic                 core_response,

    input  logic                 ctrl_read,
    input  logic                 ctrl_write,
    input  logic [BUS_WIDTH-1:0] ctrl_address,
    input  logic [BUS_WIDTH-1:0] ctrl_write_data,
    output logic [BUS_WIDTH-1:0] ctrl_read_data,
    output logic                 ctrl_response,

    input  logic                 ctrl_lock,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [BUS_WIDTH-1:0] mem_address,
    output logic [BUS_WIDTH-1:0] mem_write_data,
    input  logic [BUS_WIDTH-1:0] mem_read_data,
    input  logic                 mem_response,

    output logic                 grant_core,
    output logic                 grant_ctrl,
    output logic                 timeout_error,
    input  logic                 clear_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Watchdog compare value; only meaningful when the watchdog is enabled.
    localparam bit TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam int TO_LAST_INT = TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [TIMEOUT_BITS-1:0] TO_LAST = TO_LAST_INT[TIMEOUT_BITS-1:0];

    state_t                  state_q;
    state_t                  state_d;

    // last_grant_q doubles as the owner of the transaction in flight:
    // it is written only at the granting edge, so during BUSY/RESP it
    // always names the current winner. 1 = ctrl, 0 = core.
    logic                    last_grant_q;
    logic                    op_write_q;
    logic [BUS_WIDTH-1:0]    addr_q;
    logic [BUS_WIDTH-1:0]    wdata_q;
    logic [TIMEOUT_BITS-1:0] count_q;
    logic [BUS_WIDTH-1:0]    core_rdata_q;
    logic [BUS_WIDTH-1:0]    ctrl_rdata_q;
    logic                    timeout_q;

    logic                    core_req;
    logic                    ctrl_req;
    logic                    pick_ctrl;
    logic                    start;
    logic                    done_ok;
    logic                    done_to;

    // A locked-out core is simply invisible to the arbiter.
    assign core_req = (core_read | core_write) & ~ctrl_lock;
    assign ctrl_req = ctrl_read | ctrl_write;

    // On contention round-robin takes the side opposite the previous
    // winner; fixed priority always hands it to ctrl.
    always_comb begin
        pick_ctrl = ctrl_req;
        if (ctrl_req && core_req) begin
            pick_ctrl = ROUND_ROBIN ? ~last_grant_q : 1'b1;
        end
    end

    // Next-state and output decode. All outputs come from registered
    // state, so an asynchronous reset drops the strobes immediately.
    always_comb begin
        state_d        = state_q;
        start          = 1'b0;
        done_ok        = 1'b0;
        done_to        = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        grant_core     = 1'b0;
        grant_ctrl     = 1'b0;
        core_response  = 1'b0;
        ctrl_response  = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_req || ctrl_req) begin
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                mem_read       = ~op_write_q;
                mem_write      = op_write_q;
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                grant_core     = ~last_grant_q;
                grant_ctrl     = last_grant_q;
                if (mem_response) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (TIMEOUT_EN && (count_q == TO_LAST)) begin
                    done_to = 1'b1;
                    state_d = RESP;
                end
            end

            RESP: begin
                grant_core    = ~last_grant_q;
                grant_ctrl    = last_grant_q;
                core_response = ~last_grant_q;
                ctrl_response = last_grant_q;
                state_d       = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction latch and watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b0;
            op_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
        end else if (start) begin
            last_grant_q <= pick_ctrl;
            // read+write together is treated as a write
            op_write_q   <= pick_ctrl ? ctrl_write      : core_write;
            addr_q       <= pick_ctrl ? ctrl_address    : core_address;
            wdata_q      <= pick_ctrl ? ctrl_write_data : core_write_data;
            count_q      <= '0;
        end else if ((state_q == BUSY) && !done_ok && !done_to && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Read data registers: only a completed read touches them. A timed-out
    // read returns all-ones so software can spot it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_rdata_q <= '0;
            ctrl_rdata_q <= '0;
        end else if ((done_ok || done_to) && !op_write_q) begin
            if (last_grant_q) begin
                ctrl_rdata_q <= done_ok ? mem_read_data : '1;
            end else begin
                core_rdata_q <= done_ok ? mem_read_data : '1;
            end
        end
    end

    // Sticky error flag; a fresh expiry beats a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else if (done_to) begin
            timeout_q <= 1'b1;
        end else if (clear_error) begin
            timeout_q <= 1'b0;
        end
    end

    assign core_read_data = core_rdata_q;
    assign ctrl_read_data = ctrl_rdata_q;
    assign timeout_error  = timeout_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Purpose : directed self-checking bench for memory_arbiter.
// Latency : n/a.
// Backpr. : n/a.
module tb_memory_arbiter;

    logic        clk;
    logic        reset;
    logic        core_read, core_write, ctrl_read, ctrl_write, ctrl_lock, clear_error;
    logic [31:0] core_address, core_write_data, ctrl_address, ctrl_write_data;
    logic [31:0] mem_read_data;
    logic        auto_resp, man_resp;

    // main instance: round-robin, 4-cycle watchdog
    logic [31:0] core_read_data, ctrl_read_data, mem_address, mem_write_data;
    logic        core_response, ctrl_response, mem_read, mem_write, mem_response;
    logic        grant_core, grant_ctrl, timeout_error;

    // second instance: fixed ctrl priority, watchdog disabled, memory always answers at once
    logic [31:0] core_read_data_b, ctrl_read_data_b, mem_address_b, mem_write_data_b;
    logic        core_response_b, ctrl_response_b, mem_read_b, mem_write_b, mem_response_b;
    logic        grant_core_b, grant_ctrl_b, timeout_error_b;

    assign mem_response   = auto_resp ? (mem_read | mem_write) : man_resp;
    assign mem_response_b = mem_read_b | mem_write_b;

    memory_arbiter #(.BUS_WIDTH(32), .ROUND_ROBIN(1'b1), .TIMEOUT_BITS(8), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .core_read(core_read), .core_write(core_write), .core_address(core_address),
        .core_write_data(core_write_data), .core_read_data(core_read_data), .core_response(core_response),
        .ctrl_read(ctrl_read), .ctrl_write(ctrl_write), .ctrl_address(ctrl_address),
        .ctrl_write_data(ctrl_write_data), .ctrl_read_data(ctrl_read_data), .ctrl_response(ctrl_response),
        .ctrl_lock(ctrl_lock),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_response(mem_response),
        .grant_core(grant_core), .grant_ctrl(grant_ctrl),
        .timeout_error(timeout_error), .clear_error(clear_error)
    );

    memory_arbiter #(.BUS_WIDTH(32), .ROUND_ROBIN(1'b0), .TIMEOUT_BITS(8), .TIMEOUT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset),
        .core_read(core_read), .core_write(core_write), .core_address(core_address),
        .core_write_data(core_write_data), .core_read_data(core_read_data_b), .core_response(core_response_b),
        .ctrl_read(ctrl_read), .ctrl_write(ctrl_write), .ctrl_address(ctrl_address),
        .ctrl_write_data(ctrl_write_data), .ctrl_read_data(ctrl_read_data_b), .ctrl_response(ctrl_response_b),
        .ctrl_lock(ctrl_lock),
        .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_address(mem_address_b),
        .mem_write_data(mem_write_data_b), .mem_read_data(32'h0), .mem_response(mem_response_b),
        .grant_core(grant_core_b), .grant_ctrl(grant_ctrl_b),
        .timeout_error(timeout_error_b), .clear_error(clear_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // event counters and completion order (1 = ctrl, 0 = core), sampled mid-cycle
    int n_rd = 0, n_core_resp = 0, n_ctrl_resp = 0, n_gcore = 0, n_both = 0;
    bit seq[$];
    bit seq_b[$];

    always @(negedge clk) begin
        if (mem_read)                n_rd++;
        if (core_response)           n_core_resp++;
        if (ctrl_response)           n_ctrl_resp++;
        if (grant_core)              n_gcore++;
        if (grant_core && grant_ctrl) n_both++;
        if (grant_core_b && grant_ctrl_b) n_both++;
        if (ctrl_response)   seq.push_back(1'b1);
        if (core_response)   seq.push_back(1'b0);
        if (ctrl_response_b) seq_b.push_back(1'b1);
        if (core_response_b) seq_b.push_back(1'b0);
    end

    // step to just after the next falling edge: outputs are stable, inputs safe to change
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        core_read = 0; core_write = 0; ctrl_read = 0; ctrl_write = 0;
        ctrl_lock = 0; clear_error = 0; auto_resp = 0; man_resp = 0;
        core_address = 0; core_write_data = 0; ctrl_address = 0; ctrl_write_data = 0;
        mem_read_data = 0;
        tick(2);
        total++; if ({mem_read, mem_write, grant_core, grant_ctrl} !== 4'b0) begin
            bad++; $display("FAIL reset_strobes: got %b want 0000", {mem_read, mem_write, grant_core, grant_ctrl});
        end
        total++; if ({core_response, ctrl_response, timeout_error} !== 3'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {core_response, ctrl_response, timeout_error});
        end
        total++; if ({core_read_data, ctrl_read_data, mem_address} !== 96'h0) begin
            bad++; $display("FAIL reset_data: got %h %h %h want 0", core_read_data, ctrl_read_data, mem_address);
        end
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_core_read();
        int r0, c0;
        r0 = n_rd; c0 = n_core_resp;
        core_read = 1; core_address = 32'h10;
        tick(1);  // BUSY 1
        total++; if (mem_read !== 1'b1 || mem_address !== 32'h10) begin
            bad++; $display("FAIL cr_strobe: got rd=%b addr=%h want rd=1 addr=00000010", mem_read, mem_address);
        end
        total++; if (grant_core !== 1'b1 || grant_ctrl !== 1'b0) begin
            bad++; $display("FAIL cr_grant: got core=%b ctrl=%b want 1 0", grant_core, grant_ctrl);
        end
        tick(1);  // BUSY 2: memory answers
        man_resp = 1; mem_read_data = 32'hCAFEBABE;
        tick(1);  // RESP
        man_resp = 0;
        total++; if (core_response !== 1'b1 || mem_read !== 1'b0 || grant_core !== 1'b1) begin
            bad++; $display("FAIL cr_resp: got resp=%b rd=%b gnt=%b want 1 0 1", core_response, mem_read, grant_core);
        end
        total++; if (core_read_data !== 32'hCAFEBABE) begin
            bad++; $display("FAIL cr_data: got %h want cafebabe", core_read_data);
        end
        core_read = 0;
        tick(1);  // IDLE
        total++; if (core_response !== 1'b0 || grant_core !== 1'b0) begin
            bad++; $display("FAIL cr_idle: got resp=%b gnt=%b want 0 0", core_response, grant_core);
        end
        total++; if (n_rd - r0 != 2 || n_core_resp - c0 != 1) begin
            bad++; $display("FAIL cr_counts: got rd=%0d resp=%0d want 2 1", n_rd - r0, n_core_resp - c0);
        end
    endtask

    task automatic test_read_write_both();
        core_read = 1; core_write = 1; core_address = 32'h20; core_write_data = 32'h12345678;
        tick(1);  // BUSY
        total++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_write_data !== 32'h12345678) begin
            bad++; $display("FAIL rw_write: got wr=%b rd=%b data=%h want 1 0 12345678", mem_write, mem_read, mem_write_data);
        end
        man_resp = 1; mem_read_data = 32'hDEADBEEF;
        tick(1);  // RESP
        man_resp = 0;
        total++; if (core_response !== 1'b1) begin
            bad++; $display("FAIL rw_resp: got %b want 1", core_response);
        end
        core_read = 0; core_write = 0;
        tick(1);
        total++; if (core_read_data !== 32'hCAFEBABE) begin
            bad++; $display("FAIL rw_rdata_kept: got %h want cafebabe", core_read_data);
        end
    endtask

    task automatic test_round_robin();
        int s, sb, guard;
        reset = 1; tick(1); reset = 0;
        s = seq.size(); sb = seq_b.size();
        auto_resp = 1;
        core_read = 1; core_address = 32'h30;
        ctrl_read = 1; ctrl_address = 32'h40;
        guard = 0;
        while ((seq.size() - s < 6 || seq_b.size() - sb < 6) && guard < 40) begin
            tick(1);
            guard++;
        end
        core_read = 0; ctrl_read = 0;
        tick(2);
        auto_resp = 0;
        total++; if (guard >= 40) begin
            bad++; $display("FAIL rr_budget: got %0d completions want 6", seq.size() - s);
        end
        for (int i = 0; i < 6; i++) begin
            if (s + i < seq.size()) begin
                total++; if (seq[s + i] !== ((i % 2) == 0)) begin
                    bad++; $display("FAIL rr_order[%0d]: got ctrl=%b want ctrl=%b", i, seq[s + i], (i % 2) == 0);
                end
            end
            if (sb + i < seq_b.size()) begin
                total++; if (seq_b[sb + i] !== 1'b1) begin
                    bad++; $display("FAIL prio_order[%0d]: got ctrl=%b want ctrl=1", i, seq_b[sb + i]);
                end
            end
        end
    endtask

    task automatic test_lock();
        int c0, g0, k0, guard;
        logic seen;
        c0 = n_ctrl_resp; g0 = n_gcore; k0 = n_core_resp;
        auto_resp = 1;
        ctrl_lock = 1;
        core_write = 1; core_address = 32'h44; core_write_data = 32'h11;
        for (int w = 0; w < 4; w++) begin
            ctrl_write = 1; ctrl_address = 32'h100 + w; ctrl_write_data = 32'hA0 + w;
            guard = 0;
            while (ctrl_response !== 1'b1 && guard < 10) begin
                tick(1);
                guard++;
            end
            ctrl_write = 0;
            tick(1);
        end
        total++; if (n_ctrl_resp - c0 != 4) begin
            bad++; $display("FAIL lock_ctrl_resp: got %0d want 4", n_ctrl_resp - c0);
        end
        total++; if (n_gcore - g0 != 0 || n_core_resp - k0 != 0) begin
            bad++; $display("FAIL lock_core_blocked: got grants=%0d resp=%0d want 0 0", n_gcore - g0, n_core_resp - k0);
        end
        ctrl_lock = 0;
        seen = 0; guard = 0;
        while (!seen && guard < 5) begin
            tick(1);
            guard++;
            seen = grant_core;
        end
        total++; if (seen !== 1'b1 || mem_write !== 1'b1 || mem_address !== 32'h44 || mem_write_data !== 32'h11) begin
            bad++; $display("FAIL lock_release: got gnt=%b wr=%b addr=%h data=%h want 1 1 00000044 00000011",
                            seen, mem_write, mem_address, mem_write_data);
        end
        guard = 0;
        while (core_response !== 1'b1 && guard < 10) begin
            tick(1);
            guard++;
        end
        core_write = 0;
        tick(1);
        auto_resp = 0;
    endtask

    task automatic test_timeout();
        int k, r0;
        r0 = n_rd;
        ctrl_read = 1; ctrl_address = 32'h200;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (ctrl_response !== 1'b1 && k < 12);
        total++; if (k != 5) begin
            bad++; $display("FAIL to_latency: got %0d cycles want 5", k);
        end
        total++; if (ctrl_read_data !== 32'hFFFFFFFF || timeout_error !== 1'b1) begin
            bad++; $display("FAIL to_result: got data=%h err=%b want ffffffff 1", ctrl_read_data, timeout_error);
        end
        total++; if (n_rd - r0 != 4) begin
            bad++; $display("FAIL to_busy_cycles: got %0d want 4", n_rd - r0);
        end
        ctrl_read = 0;
        tick(1);
        total++; if (timeout_error !== 1'b1) begin
            bad++; $display("FAIL to_sticky: got %b want 1", timeout_error);
        end
        clear_error = 1;
        tick(1);
        clear_error = 0;
        total++; if (timeout_error !== 1'b0) begin
            bad++; $display("FAIL to_clear: got %b want 0", timeout_error);
        end
        // clear held across a second expiry: the set must win
        ctrl_read = 1; clear_error = 1;
        k = 0;
        do begin
            tick(1);
            k++;
        end while (ctrl_response !== 1'b1 && k < 12);
        total++; if (timeout_error !== 1'b1) begin
            bad++; $display("FAIL to_set_wins: got %b want 1", timeout_error);
        end
        ctrl_read = 0;
        tick(1);
        clear_error = 0;
        total++; if (timeout_error !== 1'b0) begin
            bad++; $display("FAIL to_clear2: got %b want 0", timeout_error);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        c0 = n_core_resp;
        core_read = 1; core_address = 32'h30;
        tick(1);  // BUSY
        total++; if (mem_read !== 1'b1) begin
            bad++; $display("FAIL rm_busy: got %b want 1", mem_read);
        end
        reset = 1;
        #1;
        total++; if (mem_read !== 1'b0 || grant_core !== 1'b0) begin
            bad++; $display("FAIL rm_async_drop: got rd=%b gnt=%b want 0 0", mem_read, grant_core);
        end
        tick(2);
        reset = 0;
        tick(1);  // re-issued read, BUSY
        man_resp = 1; mem_read_data = 32'h55AA55AA;
        tick(1);  // RESP
        man_resp = 0;
        total++; if (core_response !== 1'b1 || core_read_data !== 32'h55AA55AA) begin
            bad++; $display("FAIL rm_reissue: got resp=%b data=%h want 1 55aa55aa", core_response, core_read_data);
        end
        core_read = 0;
        tick(1);
        total++; if (n_core_resp - c0 != 1) begin
            bad++; $display("FAIL rm_resp_count: got %0d want 1", n_core_resp - c0);
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_read_write_both();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        total++; if (n_both != 0) begin
            bad++; $display("FAIL grant_exclusive: got %0d overlap cycles want 0", n_both);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
